// File: rtl/psum_collector.sv
// Collects PE top-row psums, accumulates them over input-channel passes with saturation,
// then drains rows over a valid/ready stream. Optional ReLU on output via PSUM_RELU_EN.
module psum_collector #(
  parameter int BITWIDTH  = 16,
  parameter int PE_X_SIZE = 3,
  parameter int ACC_WIDTH = 24,
  parameter int DEPTH     = 4,
  parameter int PASS_W    = 10,
  parameter int ROW_W     = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rstb,
  input  logic                           start,
  input  logic [PASS_W-1:0]              num_passes,
  input  logic [ROW_W-1:0]               num_rows,
  input  logic [BITWIDTH*PE_X_SIZE-1:0]  psum_in,
  input  logic                           psum_valid,
  output logic                           psum_ready,
  output logic [ACC_WIDTH*PE_X_SIZE-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           sat_flag
);

  localparam int IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RowBits = ACC_WIDTH * PE_X_SIZE;
  localparam int ExtW    = ACC_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e              state_q;
  logic [PASS_W-1:0]   passes_q, pass_cnt_q;
  logic [ROW_W-1:0]    rows_q, wr_row_q, rd_row_q;
  logic [RowBits-1:0]  buffer_q [DEPTH];
  logic                done_q, sat_q;

  logic [PASS_W-1:0]    passes_eff;
  logic [ROW_W-1:0]     rows_eff;
  logic [RowBits-1:0]   wr_entry, wr_next, rd_entry;
  logic [PE_X_SIZE-1:0] lane_sat;
  logic signed [ExtW-1:0] ext_in, ext_acc, lane_sum;
  logic                 last_row, last_pass, last_rd;

  always_comb begin
    passes_eff = (num_passes == '0) ? PASS_W'(1) : num_passes;
    if (num_rows == '0)                 rows_eff = ROW_W'(1);
    else if (num_rows > ROW_W'(DEPTH))  rows_eff = ROW_W'(DEPTH);
    else                                rows_eff = num_rows;
  end

  assign wr_entry  = buffer_q[wr_row_q[IdxW-1:0]];
  assign rd_entry  = buffer_q[rd_row_q[IdxW-1:0]];
  assign last_row  = (wr_row_q == rows_q - ROW_W'(1));
  assign last_pass = (pass_cnt_q == passes_q - PASS_W'(1));
  assign last_rd   = (rd_row_q == rows_q - ROW_W'(1));

  // First pass overwrites so stale entries from a previous job never leak in.
  always_comb begin
    wr_next  = '0;
    lane_sat = '0;
    ext_in   = '0;
    ext_acc  = '0;
    lane_sum = '0;
    for (int j = 0; j < PE_X_SIZE; j++) begin
      ext_in   = ExtW'($signed(psum_in[j*BITWIDTH +: BITWIDTH]));
      ext_acc  = ExtW'($signed(wr_entry[j*ACC_WIDTH +: ACC_WIDTH]));
      lane_sum = ext_acc + ext_in;
      if (pass_cnt_q == '0) begin
        wr_next[j*ACC_WIDTH +: ACC_WIDTH] = ext_in[ACC_WIDTH-1:0];
      end else if (lane_sum[ACC_WIDTH] != lane_sum[ACC_WIDTH-1]) begin
        lane_sat[j] = 1'b1;
        wr_next[j*ACC_WIDTH +: ACC_WIDTH] = lane_sum[ACC_WIDTH] ?
            {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        wr_next[j*ACC_WIDTH +: ACC_WIDTH] = lane_sum[ACC_WIDTH-1:0];
      end
    end
  end

`ifdef PSUM_RELU_EN
  always_comb begin
    out_data = '0;
    for (int j = 0; j < PE_X_SIZE; j++) begin
      out_data[j*ACC_WIDTH +: ACC_WIDTH] = rd_entry[j*ACC_WIDTH + ACC_WIDTH - 1] ?
          '0 : rd_entry[j*ACC_WIDTH +: ACC_WIDTH];
    end
  end
`else
  assign out_data = rd_entry;
`endif

  assign psum_ready = (state_q == StAccum);
  assign out_valid  = (state_q == StDrain);
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign sat_flag   = sat_q;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q    <= StIdle;
      passes_q   <= '0;
      rows_q     <= '0;
      pass_cnt_q <= '0;
      wr_row_q   <= '0;
      rd_row_q   <= '0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      for (int d = 0; d < DEPTH; d++) buffer_q[d] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            passes_q   <= passes_eff;
            rows_q     <= rows_eff;
            pass_cnt_q <= '0;
            wr_row_q   <= '0;
            rd_row_q   <= '0;
            sat_q      <= 1'b0;
            state_q    <= StAccum;
          end
        end
        StAccum: begin
          if (psum_valid) begin
            buffer_q[wr_row_q[IdxW-1:0]] <= wr_next;
            if (|lane_sat) sat_q <= 1'b1;
            if (last_row) begin
              wr_row_q   <= '0;
              pass_cnt_q <= pass_cnt_q + PASS_W'(1);
              if (last_pass) state_q <= StDrain;
            end else begin
              wr_row_q <= wr_row_q + ROW_W'(1);
            end
          end
        end
        StDrain: begin
          if (out_ready) begin
            if (last_rd) begin
              rd_row_q <= '0;
              done_q   <= 1'b1;
              state_q  <= StIdle;
            end else begin
              rd_row_q <= rd_row_q + ROW_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: an integer model predicts drained rows, a negedge
// process compares every valid row, and the stimulus checks timing and flag behaviour.
module tb_psum_collector;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start;
  logic [9:0]  num_passes;
  logic [2:0]  num_rows;
  logic [47:0] psum_in;
  logic        psum_valid;
  logic        psum_ready;
  logic [71:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        sat_flag;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [47:0] beat_q[$];
  logic [71:0] exp_q[$];
  logic        exp_sat;

  psum_collector dut (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .num_passes (num_passes),
    .num_rows   (num_rows),
    .psum_in    (psum_in),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] mk(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [71:0] mkrow(input int a, input int b, input int c);
    return {24'(c), 24'(b), 24'(a)};
  endfunction

  // Plain integer accumulation over the beat list, row-major within each pass.
  function automatic void model_job(input int p, input int r);
    int pe, re;
    longint acc [4][3];
    longint v;
    logic [15:0] s;
    logic signed [63:0] t;
    logic [71:0] row;
    pe = (p == 0) ? 1 : p;
    re = (r == 0) ? 1 : ((r > 4) ? 4 : r);
    exp_sat = 1'b0;
    for (int k = 0; k < pe * re; k++) begin
      for (int j = 0; j < 3; j++) begin
        s = beat_q[k][j*16 +: 16];
        v = longint'($signed(s));
        if (k < re) acc[k % re][j] = v;
        else begin
          acc[k % re][j] = acc[k % re][j] + v;
          if (acc[k % re][j] > 64'sd8388607) begin
            acc[k % re][j] = 64'sd8388607;
            exp_sat = 1'b1;
          end else if (acc[k % re][j] < -64'sd8388608) begin
            acc[k % re][j] = -64'sd8388608;
            exp_sat = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < re; i++) begin
      row = '0;
      for (int j = 0; j < 3; j++) begin
        t = acc[i][j];
`ifdef PSUM_RELU_EN
        if (t < 0) t = 0;
`endif
        row[j*24 +: 24] = t[23:0];
      end
      exp_q.push_back(row);
    end
  endfunction

  // Row comparison on every cycle the stream is valid; pops on handshake.
  always @(negedge clk) begin
    if (rstb === 1'b0) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("rows_pending", 72'(exp_q.size() != 0), 72'd1);
        else begin
          check("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (done) check("done_drained", {exp_q.size() == 0, busy, out_valid}, 3'b100);
    end
  end

  task automatic do_start(input int p, input int r);
    start      = 1'b1;
    num_passes = 10'(p);
    num_rows   = 3'(r);
    tick();
    start = 1'b0;
    check("start_busy_ready_sat", {busy, psum_ready, sat_flag}, 3'b110);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic run_job(input int p, input int r, input int hold, input bit poke,
                         input logic [71:0] pin0);
    int pe, re, c0, n;
    pe = (p == 0) ? 1 : p;
    re = (r == 0) ? 1 : ((r > 4) ? 4 : r);
    exp_q.delete();
    model_job(p, r);
    check("model_pin", exp_q[0], pin0);
    do_start(p, r);
    if (poke) begin
      start = 1'b1; num_passes = 10'd5; num_rows = 3'd3;
      tick();
      start = 1'b0;
    end
    c0 = cyc;
    for (int k = 0; k < pe * re; k++) begin
      psum_valid = 1'b1;
      psum_in    = beat_q[k];
      check("psum_ready", psum_ready, 1);
      tick();
    end
    psum_valid = 1'b0;
    check("final_beat_state", {out_valid, psum_ready}, 2'b10);
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) tick();
      out_ready = 1'b1;
    end
    wait_done(n);
    if (hold == 0) check("latency", 72'(cyc - c0), 72'(pe * re + re));
    check("sat_flag", sat_flag, exp_sat);
    tick();
    check("done_pulse_idle", {done, busy, out_valid}, 3'b000);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b1; start = 1'b0; num_passes = '0; num_rows = '0;
    psum_in = '0; psum_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {psum_ready, out_valid, busy, done, sat_flag, out_data}, '0);
    rstb = 1'b0;
    tick();

    // Single pass, two rows.
    beat_q = {mk(1, 2, 3), mk(4, 5, 6)};
    run_job(1, 2, 0, 1'b0, mkrow(1, 2, 3));

    // Three passes over one row.
    beat_q = {mk(10, -5, 7), mk(10, -5, 7), mk(10, -5, 7)};
`ifdef PSUM_RELU_EN
    run_job(3, 1, 0, 1'b0, mkrow(30, 0, 21));
`else
    run_job(3, 1, 0, 1'b0, mkrow(30, -15, 21));
`endif

    // Saturation on lane 0 after 257 passes of 0x7FFF.
    beat_q.delete();
    for (int k = 0; k < 300; k++) beat_q.push_back(mk(32767, 1, -1));
`ifdef PSUM_RELU_EN
    run_job(300, 1, 0, 1'b0, mkrow(8388607, 300, 0));
`else
    run_job(300, 1, 0, 1'b0, mkrow(8388607, 300, -300));
`endif
    check("sat_sticky_idle", sat_flag, 1);

    // Backpressure: hold row 0 for five cycles.
    beat_q = {mk(-1, -2, -3), mk(100, -200, 300)};
`ifdef PSUM_RELU_EN
    run_job(1, 2, 5, 1'b0, mkrow(0, 0, 0));
`else
    run_job(1, 2, 5, 1'b0, mkrow(-1, -2, -3));
`endif

    // Abort mid-accumulation with reset, then a fresh job.
    exp_q.delete();
    do_start(3, 1);
    psum_valid = 1'b1; psum_in = mk(100, 200, 300);
    tick();
    psum_valid = 1'b0;
    rstb = 1'b1;
    #1;
    check("mid_reset_outputs", {psum_ready, out_valid, busy, done, sat_flag, out_data}, '0);
    tick();
    rstb = 1'b0;
    tick();
    beat_q = {mk(9, 9, 9)};
    run_job(1, 1, 0, 1'b0, mkrow(9, 9, 9));

    // Beat offered in IDLE is refused; zero config runs 1x1; restart mid-ACCUM ignored.
    psum_valid = 1'b1; psum_in = mk(77, 77, 77);
    check("idle_not_ready", {psum_ready, busy}, 2'b00);
    tick();
    psum_valid = 1'b0;
    check("idle_still_idle", busy, 0);
    beat_q = {mk(-4, 5, -6)};
`ifdef PSUM_RELU_EN
    run_job(0, 0, 0, 1'b1, mkrow(0, 5, 0));
`else
    run_job(0, 0, 0, 1'b1, mkrow(-4, 5, -6));
`endif

    // Row count above DEPTH clamps to four rows.
    beat_q = {mk(1, 1, 1), mk(2, 2, 2), mk(3, 3, 3), mk(4, 4, 4)};
    run_job(1, 7, 0, 1'b0, mkrow(1, 1, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
# psum_collector

Parametrised ofmap collection stage that sits directly above the top row of the PE array in the accelerator. It captures the PE_X_SIZE column psums emitted per array pass and accumulates them across multiple input-channel passes in a local flop buffer of up to DEPTH ofmap rows. It uses saturating wide-precision arithmetic, then drains the finished rows through a valid/ready stream. It replaces the direct wiring of top-row psums to the ofmap port.

## Interface
- BITWIDTH, 16, width of each incoming PE psum (signed, two's complement)
- PE_X_SIZE, 3, number of PE columns; psum lanes per beat
- ACC_WIDTH, 24, accumulator width per lane (signed); must be > BITWIDTH
- DEPTH, 4, maximum ofmap rows buffered per job
- PASS_W, 10, width of the pass-count configuration
- ROW_W, $clog2(DEPTH)+1, width of the row-count configuration
---
- clk  input  1  clock; all state on rising edge
- rstb  input  1  reset; asynchronous, active-high (asserted = 1)
- start  input  1  one-cycle job start; sampled only in IDLE
- num_passes  input  PASS_W  passes to accumulate; sampled on start; 0 treated as 1
- num_rows  input  ROW_W  rows per pass; sampled on start; 0 treated as 1, values > DEPTH clamped to DEPTH
- psum_in  input  BITWIDTH*PE_X_SIZE  lane j at [j*BITWIDTH +: BITWIDTH]
- psum_valid  input  1  psum_in beat valid
- psum_ready  output  1  high only in ACCUM
- out_data  output  ACC_WIDTH*PE_X_SIZE  current drained row, lane j at [j*ACC_WIDTH +: ACC_WIDTH]
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accept
- busy  output  1  high in ACCUM and DRAIN
- done  output  1  one-cycle pulse on the final drain handshake
- sat_flag  output  1  sticky; set on any lane saturation, cleared on accepted start

## Operation
- FSM with 3 states: IDLE, ACCUM, DRAIN.
- IDLE:
  - On start, latch the effective passes P and rows R.
  - Clear wr_row, pass_cnt, rd_row, and sat_flag.
  - Go to ACCUM.
- ACCUM: each psum_valid & psum_ready beat updates buffer[wr_row] lane-wise:
  - pass_cnt == 0: entry = sign_extend(psum lane). The write overwrites; stale data is never summed.
  - pass_cnt > 0: entry = sat(entry + sign_extend(psum lane)).
  - Row/pass stepping: wr_row increments. When wr_row == R-1, it wraps to 0 and pass_cnt increments.
  - The beat with pass_cnt == P-1 and wr_row == R-1 moves the FSM to DRAIN.
- Saturation:
  - The sum is computed at ACC_WIDTH+1 bits.
  - It clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Any lane clamping sets sat_flag.
- DRAIN:
  - out_valid = 1; out_data = buffer[rd_row], with the output transform applied.
  - On out_valid & out_ready, rd_row increments.
  - The handshake at rd_row == R-1 pulses done and returns to IDLE.
- Ignored inputs:
  - start outside IDLE is ignored.
  - psum_valid outside ACCUM is ignored; psum_ready is 0 and the buffer is unchanged.
- Buffer entries beyond R are untouched and never output.

## Timing
- Reset values: all outputs 0, state IDLE, buffer cleared to 0.
- Reset asserted at any point, including mid-ACCUM or mid-DRAIN, aborts the job immediately. No done is produced.
- start at cycle t: busy = 1 and psum_ready = 1 from cycle t+1.
- Throughput: one psum beat per cycle in ACCUM; one row per cycle in DRAIN with out_ready held high.
- Final accumulating beat at cycle t:
  - out_valid = 1 from cycle t+1, showing row 0 with its final value.
  - psum_ready = 0 from cycle t+1.
- Backpressure: while out_valid & !out_ready, out_data and out_valid hold stable.
- done: asserted the cycle after the last handshake, for exactly 1 cycle.
- State after done: busy = 0 and out_valid = 0 the same cycle; a new start is accepted from that cycle.
- Total minimum job latency: P*R + R cycles from the first beat to done.

## Configuration
- PSUM_RELU_EN defined: each drained lane is max(entry, 0). Clamping happens on output only; the buffer keeps signed sums.
- PSUM_RELU_EN undefined: out_data is the raw signed accumulated entry.
- sat_flag behaviour is identical in both builds.

## Test plan
- Single pass:
  - Stimulus: num_passes=1, num_rows=2; beats {1,2,3}, {4,5,6}; out_ready=1.
  - Required: rows {1,2,3}, {4,5,6}; done 1 cycle after the second handshake; sat_flag=0.
- Multi-pass accumulation:
  - Stimulus: num_passes=3, num_rows=1; beat {10,-5,7} three times.
  - Required: one row {30,-15,21} (without PSUM_RELU_EN) or {30,0,21} (with PSUM_RELU_EN).
- Saturation:
  - Stimulus: num_passes=300, num_rows=1; lane0 beats 0x7FFF (3-lane config, ACC_WIDTH=24).
  - Required: lane0 output 0x7FFFFF; sat_flag=1 until the next start.
- Backpressure:
  - Stimulus: num_rows=2; out_ready held low for 5 cycles after out_valid rises.
  - Required: out_data holds row 0 for those 5 cycles; no row skipped; done after the second accept.
- Reset mid-operation:
  - Stimulus: assert rstb after 1 of 3 passes; release; start again with num_passes=1, num_rows=1, beat {9,9,9}.
  - Required:
    - During reset, all outputs are 0.
    - New job outputs {9,9,9}; no residue from the aborted job.
- Clamp and ignore rules:
  - Stimulus: num_rows=0, num_passes=0; psum_valid asserted in IDLE beforehand; start pulsed again mid-ACCUM.
  - Required:
    - Job runs as 1x1.
    - The IDLE beat is not captured.
    - The second start has no effect.
